// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA timing recovery and pixel capture with lock tracking
// Recovers x/y from HS/VS edges, locks after one clean frame, emits visible pixels.
module vga_capture #(
  parameter int H_TOTAL   = 1040,
  parameter int V_TOTAL   = 666,
  parameter int H_START   = 64,
  parameter int V_START   = 22,
  parameter int H_VISIBLE = 800,
  parameter int V_VISIBLE = 600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        HS,
  input  logic        VS,
  input  logic [11:0] colour_in,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic [11:0] colour_out,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        err
);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  localparam logic [11:0] LP_H_LO   = 12'(H_START);
  localparam logic [11:0] LP_H_HI   = 12'(H_START + H_VISIBLE);
  localparam logic [10:0] LP_V_LO   = 11'(V_START);
  localparam logic [10:0] LP_V_HI   = 11'(V_START + V_VISIBLE);
  localparam logic [10:0] LP_H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  LP_V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] LP_H_OFF  = 11'(H_START);
  localparam logic [9:0]  LP_V_OFF  = 10'(V_START);

  state_t      r_state, w_state_nxt;
  logic        r_hs_prev, r_vs_prev, r_pending, r_bad, w_bad_nxt;
  logic [10:0] r_hcnt, w_hcnt_nxt;
  logic [9:0]  r_vcnt, w_vcnt_nxt;
  logic        w_hs_rise, w_vs_rise, w_marker, w_line_err, w_frame_err, w_err_nxt;
  logic        w_h_in, w_v_in, w_visible;
  logic [10:0] w_x;
  logic [9:0]  w_y;
  logic [10:0] r_x;
  logic [9:0]  r_y;
  logic [11:0] r_colour;
  logic        r_pix_valid, r_frame_start, r_err;

  assign w_hs_rise   = pix_en & ~r_hs_prev & HS;
  assign w_vs_rise   = pix_en & ~r_vs_prev & VS;
  // A VS rise coincident with an HS rise is consumed immediately as the marker
  assign w_marker    = w_hs_rise & (r_pending | w_vs_rise);
  assign w_line_err  = w_hs_rise & (r_hcnt != LP_H_LAST);
  assign w_frame_err = w_marker & (r_vcnt != LP_V_LAST);

  always_comb begin
    w_hcnt_nxt = r_hcnt;
    if (w_hs_rise)
      w_hcnt_nxt = '0;
    else if (pix_en && r_hcnt != 11'h7FF)
      w_hcnt_nxt = r_hcnt + 11'd1;
  end

  always_comb begin
    w_vcnt_nxt = r_vcnt;
    if (w_marker)
      w_vcnt_nxt = '0;
    else if (w_hs_rise && r_vcnt != 10'h3FF)
      w_vcnt_nxt = r_vcnt + 10'd1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bad_nxt   = r_bad;
    w_err_nxt   = 1'b0;
    case (r_state)
      SEARCH: begin
        if (w_marker) begin
          w_state_nxt = CHECK;
          w_bad_nxt   = 1'b0;
        end
      end
      CHECK: begin
        if (w_marker) begin
          if (!r_bad && !w_line_err && !w_frame_err)
            w_state_nxt = LOCKED;
          w_bad_nxt = 1'b0;
        end else if (w_line_err) begin
          w_bad_nxt = 1'b1;
        end
      end
      LOCKED: begin
        if (w_line_err || w_frame_err) begin
          w_state_nxt = SEARCH;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = SEARCH;
    endcase
  end

  // Requiring LOCKED both before and after excludes the pixel that achieves lock
  assign w_h_in    = ({1'b0, w_hcnt_nxt} >= LP_H_LO) && ({1'b0, w_hcnt_nxt} < LP_H_HI);
  assign w_v_in    = ({1'b0, w_vcnt_nxt} >= LP_V_LO) && ({1'b0, w_vcnt_nxt} < LP_V_HI);
  assign w_visible = pix_en && (r_state == LOCKED) && (w_state_nxt == LOCKED) && w_h_in && w_v_in;
  assign w_x       = w_hcnt_nxt - LP_H_OFF;
  assign w_y       = w_vcnt_nxt - LP_V_OFF;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= SEARCH;
      r_hs_prev <= 1'b1;
      r_vs_prev <= 1'b1;
      r_pending <= 1'b0;
      r_bad     <= 1'b0;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bad   <= w_bad_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
      if (pix_en) begin
        r_hs_prev <= HS;
        r_vs_prev <= VS;
        r_pending <= w_hs_rise ? 1'b0 : (r_pending | w_vs_rise);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_err         <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_colour      <= '0;
    end else begin
      r_pix_valid   <= w_visible;
      r_frame_start <= w_visible && (w_x == 11'd0) && (w_y == 10'd0);
      r_err         <= w_err_nxt;
      r_x           <= w_visible ? w_x : 11'd0;
      r_y           <= w_visible ? w_y : 10'd0;
      r_colour      <= w_visible ? colour_in : 12'd0;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign colour_out  = r_colour;
  assign pix_valid   = r_pix_valid;
  assign frame_start = r_frame_start;
  assign err         = r_err;
  assign locked      = (r_state == LOCKED);

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 The module SHALL have parameter H_TOTAL, default 1040, giving the pixels per line.
REQ-002 The module SHALL have parameter V_TOTAL, default 666, giving the lines per frame.
REQ-003 The module SHALL have parameter H_START, default 64, giving the pixel count from the HS rising edge to the first visible pixel.
REQ-004 The module SHALL have parameter V_START, default 22, giving the line count from the frame marker to the first visible line.
REQ-005 The module SHALL have parameters H_VISIBLE, default 800, and V_VISIBLE, default 600, giving the visible pixels per line and visible lines per frame.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The module SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-008 The module SHALL have port pix_en, input, 1 bit: the pixel strobe; HS, VS and colour are sampled only when it is high.
REQ-009 The module SHALL have ports HS and VS, input, 1 bit each: the active-low sync signals.
REQ-010 The module SHALL have port colour_in, input, 12 bits: the RGB444 pixel.
REQ-011 The module SHALL have ports x, output, 11 bits, and y, output, 10 bits: the recovered coordinates.
REQ-012 The module SHALL have port colour_out, output, 12 bits: the captured pixel.
REQ-013 The module SHALL have port pix_valid, output, 1 bit: qualifies x, y and colour_out.
REQ-014 The module SHALL have port frame_start, output, 1 bit: pulses with pix_valid at x=0, y=0.
REQ-015 The module SHALL have port locked, output, 1 bit: timing lock status.
REQ-016 The module SHALL have port err, output, 1 bit: one-clk pulse on loss of lock.

Function
REQ-017 On each pix_en cycle, the module SHALL register HS and VS into hs_prev and vs_prev; a rise SHALL be defined as prev=0 and current=1.
REQ-018 The 11-bit hcnt SHALL load 0 on an HS rise, increment on every other pix_en, and saturate at 2047 without wrapping.
REQ-019 A VS rise SHALL set a pending flag; the next HS rise SHALL consume it as the frame marker.
REQ-020 The 10-bit vcnt SHALL load 0 on a frame marker, increment on every other HS rise, and saturate at 1023.
REQ-021 A line error SHALL be flagged when, at an HS rise, hcnt is not equal to H_TOTAL-1.
REQ-022 A frame error SHALL be flagged when, at a frame marker, vcnt is not equal to V_TOTAL-1.
REQ-023 The FSM SHALL have states SEARCH, CHECK and LOCKED; reset state SHALL be SEARCH.
REQ-024 In SEARCH, the FSM SHALL ignore all errors and move to CHECK on a frame marker while clearing the bad flag.
REQ-025 In CHECK, a line error SHALL set the bad flag.
REQ-026 In CHECK, at a frame marker, the FSM SHALL go to LOCKED if the bad flag is clear and no frame error occurs; otherwise it SHALL stay in CHECK and clear the bad flag.
REQ-027 In LOCKED, any line or frame error SHALL pulse err for 1 clk and move the FSM to SEARCH.
REQ-028 Output locked SHALL be high exactly while the FSM is in LOCKED.
REQ-029 A pixel SHALL be visible when the FSM is in LOCKED, H_START<=hcnt<H_START+H_VISIBLE, and V_START<=vcnt<V_START+V_VISIBLE, with all comparisons evaluated after the counter update for that pix_en.
REQ-030 For a visible pixel, one clk after its pix_en cycle, the module SHALL assert pix_valid for 1 clk with x=hcnt-H_START, y=vcnt-V_START and colour_out=colour_in as sampled.
REQ-031 In every other cycle, pix_valid SHALL be 0, x and y SHALL be 0, and colour_out SHALL be 0.
REQ-032 When the pixel that moves the FSM to LOCKED is itself visible, the pixel SHALL be treated as not visible.
REQ-033 Simultaneous HS and VS rises SHALL set the pending flag and consume it in the same pix_en cycle, producing a frame marker.
REQ-034 A VS rise while the pending flag is already set SHALL leave it set.

Reset
REQ-035 When rst is low, the module SHALL immediately clear x, y, colour_out, pix_valid, frame_start, locked and err to 0, without waiting for clk.
REQ-036 Reset SHALL set hcnt and vcnt to 0, set hs_prev and vs_prev to 1, clear the pending and bad flags, and set the FSM to SEARCH.
REQ-037 After reset deasserts mid-frame, the module SHALL require a frame marker followed by one complete good frame before asserting locked.

Verification
REQ-038 Scenario 1 SHALL apply a nominal 1040x666 stream with pix_en every 2nd clk -> locked rises at the 2nd frame marker, and the next frame gives exactly 480000 pix_valid pulses with x 0..799 and y 0..599.
REQ-039 Scenario 2 SHALL drive colour_in={x[3:0],y[3:0],4'hA} -> each pix_valid shows the matching colour_out, with 1-clk latency from the sample.
REQ-040 Scenario 3 SHALL apply, while locked, one line of 1041 pixels -> one err pulse, locked=0, and no pix_valid until one full good frame has passed.
REQ-041 Scenario 4 SHALL apply, while locked, one frame of 667 lines -> err pulse at that frame marker and locked=0.
REQ-042 Scenario 5 SHALL assert rst low at line 300, pixel 400 -> all outputs 0 in the same cycle, and lock is regained one full frame after the first marker.
REQ-043 Scenario 6 SHALL hold HS high for 3000 pixel strobes while locked -> hcnt saturates at 2047, then err pulses and locked=0 at the next HS rise.
